// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: bank of independent PWM channels.
// Register bytes arrive from the SPI front end and land in a staged register file.
// A commit pulse copies the staged values into a per-channel pending buffer.
// Each channel moves its pending values into its active set only at a period wrap,
// so a new duty cycle never cuts a running period short.
module pwm_channel_bank #(
    parameter int NUM_CH = 4,
    parameter int CW     = 16
) (
    input  logic              CLK,
    input  logic              _RST,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              commit,
    input  logic [7:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] PWMOutputs,
    output logic [NUM_CH-1:0] period_sync
);

    localparam int NUM_REG = 6 * NUM_CH;

    logic [7:0] staged [NUM_REG];

    // Staged byte file; out-of-range addresses match no entry and are dropped
    always_ff @(posedge CLK) begin
        if (!_RST) begin
            for (int i = 0; i < NUM_REG; i++) begin
                staged[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REG; i++) begin
                if (wr_addr == 8'(i)) begin
                    staged[i] <= wr_data;
                end
            end
        end
    end

    // Readback mux for the MISO path; unmapped addresses read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            if (rd_addr == 8'(i)) begin
                rd_data = staged[i];
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CW-1:0] stg_sw, stg_cnt, stg_pre;
        logic [CW-1:0] pend_sw, pend_cnt, pend_pre;
        logic          pend_vld;
        logic [CW-1:0] act_sw, act_cnt, act_pre;
        logic [CW-1:0] pre_cnt, cnt;
        logic          pwm_q, sync_q;
        logic          tick, wrap, load;

        // Byte pairs are stored big-endian: lower address holds the high byte
        assign stg_sw  = CW'({staged[6*ch+0], staged[6*ch+1]});
        assign stg_cnt = CW'({staged[6*ch+2], staged[6*ch+3]});
        assign stg_pre = CW'({staged[6*ch+4], staged[6*ch+5]});

        assign tick = (pre_cnt == act_pre);
        assign wrap = tick && (cnt == act_cnt);
        assign load = wrap && pend_vld;

        // Pending buffer, active set and period counters for one channel
        always_ff @(posedge CLK) begin
            if (!_RST) begin
                pend_sw  <= '0;
                pend_cnt <= '0;
                pend_pre <= '0;
                pend_vld <= 1'b0;
                act_sw   <= '0;
                act_cnt  <= '0;
                act_pre  <= '0;
                pre_cnt  <= '0;
                cnt      <= '0;
                pwm_q    <= 1'b0;
                sync_q   <= 1'b0;
            end else begin
                // A commit landing on the load cycle wins: the fresh snapshot stays pending
                if (commit) begin
                    pend_sw  <= stg_sw;
                    pend_cnt <= stg_cnt;
                    pend_pre <= stg_pre;
                    pend_vld <= 1'b1;
                end else if (load) begin
                    pend_vld <= 1'b0;
                end

                if (load) begin
                    act_sw  <= pend_sw;
                    act_cnt <= pend_cnt;
                    act_pre <= pend_pre;
                end

                // Both counters are already heading to zero on a wrap, so a load restarts cleanly
                if (tick) begin
                    pre_cnt <= '0;
                    cnt     <= (cnt == act_cnt) ? '0 : cnt + CW'(1);
                end else begin
                    pre_cnt <= pre_cnt + CW'(1);
                end

                pwm_q  <= (cnt < act_sw);
                sync_q <= wrap;
            end
        end

        assign PWMOutputs[ch]  = pwm_q;
        assign period_sync[ch] = sync_q;
    end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Testbench for pwm_channel_bank: register write/readback vectors, a per-cycle
// phase model feeding a scoreboard queue, and hand-written duty/commit sequences.
module tb_pwm_channel_bank;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] PWMOutputs;
    logic [3:0] period_sync;

    int errors = 0;
    int checks = 0;

    pwm_channel_bank #(.NUM_CH(4), .CW(16)) dut (
        .CLK         (CLK),
        ._RST        (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .PWMOutputs  (PWMOutputs),
        .period_sync (period_sync)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct packed {
        logic [3:0] pwm;
        logic [3:0] sync;
    } exp_t;

    vec_t vecs [19];
    exp_t sbq [$];

    // Reference model: channel state kept as a single phase index within the period
    logic [7:0]  m_stg  [24];
    logic [15:0] m_psw  [4];
    logic [15:0] m_pcnt [4];
    logic [15:0] m_ppre [4];
    logic [15:0] m_asw  [4];
    logic [15:0] m_acnt [4];
    logic [15:0] m_apre [4];
    logic        m_flag [4];
    longint      m_r    [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs currently driven
    task automatic model_edge(output exp_t e);
        longint pr, per;
        e = '0;
        if (!rst_n) begin
            for (int i = 0; i < 24; i++) m_stg[i] = '0;
            for (int c = 0; c < 4; c++) begin
                m_psw[c] = '0; m_pcnt[c] = '0; m_ppre[c] = '0;
                m_asw[c] = '0; m_acnt[c] = '0; m_apre[c] = '0;
                m_flag[c] = 1'b0; m_r[c] = 0;
            end
            return;
        end
        for (int c = 0; c < 4; c++) begin
            pr  = longint'(m_apre[c]) + 1;
            per = (longint'(m_acnt[c]) + 1) * pr;
            e.pwm[c]  = ((m_r[c] / pr) < longint'(m_asw[c]));
            e.sync[c] = (m_r[c] == per - 1);
            if (m_r[c] == per - 1) begin
                if (m_flag[c]) begin
                    m_asw[c]  = m_psw[c];
                    m_acnt[c] = m_pcnt[c];
                    m_apre[c] = m_ppre[c];
                    m_flag[c] = 1'b0;
                end
                m_r[c] = 0;
            end else begin
                m_r[c] = m_r[c] + 1;
            end
        end
        if (commit) begin
            for (int c = 0; c < 4; c++) begin
                m_psw[c]  = {m_stg[6*c+0], m_stg[6*c+1]};
                m_pcnt[c] = {m_stg[6*c+2], m_stg[6*c+3]};
                m_ppre[c] = {m_stg[6*c+4], m_stg[6*c+5]};
                m_flag[c] = 1'b1;
            end
        end
        if (wr_en && wr_addr < 8'd24) m_stg[wr_addr] = wr_data;
    endtask

    // One clock: push the expected outputs, let the edge pass, pop and compare
    task automatic cycle();
        exp_t e;
        model_edge(e);
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        e = sbq.pop_front();
        check("pwm_out", {28'd0, PWMOutputs}, {28'd0, e.pwm});
        check("period_sync", {28'd0, period_sync}, {28'd0, e.sync});
    endtask

    initial begin
        int hi0, hi1, hi2, hi3, s0, s1;
        bit found;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; rd_addr = '0;

        vecs[0]  = '{8'd0,  8'h00, 8'h00};
        vecs[1]  = '{8'd1,  8'h02, 8'h02};
        vecs[2]  = '{8'd2,  8'h00, 8'h00};
        vecs[3]  = '{8'd3,  8'h04, 8'h04};
        vecs[4]  = '{8'd4,  8'h00, 8'h00};
        vecs[5]  = '{8'd5,  8'h00, 8'h00};
        vecs[6]  = '{8'd6,  8'h01, 8'h01};
        vecs[7]  = '{8'd7,  8'h00, 8'h00};
        vecs[8]  = '{8'd8,  8'h03, 8'h03};
        vecs[9]  = '{8'd9,  8'hFF, 8'hFF};
        vecs[10] = '{8'd10, 8'h00, 8'h00};
        vecs[11] = '{8'd11, 8'h04, 8'h04};
        vecs[12] = '{8'd12, 8'h00, 8'h00};
        vecs[13] = '{8'd13, 8'h06, 8'h06};
        vecs[14] = '{8'd14, 8'h00, 8'h00};
        vecs[15] = '{8'd15, 8'h04, 8'h04};
        vecs[16] = '{8'd16, 8'h00, 8'h00};
        vecs[17] = '{8'd17, 8'h00, 8'h00};
        vecs[18] = '{8'd24, 8'hFF, 8'h00};

        // Reset: outputs and every staged byte read zero
        repeat (2) cycle();
        check("rst_pwm", {28'd0, PWMOutputs}, 32'd0);
        check("rst_sync", {28'd0, period_sync}, 32'd0);
        for (int i = 0; i < 24; i++) begin
            rd_addr = 8'(i);
            cycle();
            check("rst_rd", {24'd0, rd_data}, 32'd0);
        end
        rst_n = 1'b1;

        // Program ch0/ch1/ch2, reading each byte back right after its write
        for (int i = 0; i < 19; i++) begin
            wr_en   = 1'b1;
            wr_addr = vecs[i].addr;
            wr_data = vecs[i].data;
            rd_addr = vecs[i].addr;
            cycle();
            check("wr_rd", {24'd0, rd_data}, {24'd0, vecs[i].exp_rd});
        end
        wr_en = 1'b0;
        cycle();
        check("nocommit_pwm", {28'd0, PWMOutputs}, 32'd0);
        check("nocommit_sync", {28'd0, period_sync}, 32'hF);

        // Commit, then measure one full ch1 period starting from the first loaded cycle
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        cycle();
        hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0; s0 = 0; s1 = 0;
        for (int i = 0; i < 5120; i++) begin
            cycle();
            hi0 += int'(PWMOutputs[0]);
            hi1 += int'(PWMOutputs[1]);
            hi2 += int'(PWMOutputs[2]);
            hi3 += int'(PWMOutputs[3]);
            s0  += int'(period_sync[0]);
            s1  += int'(period_sync[1]);
        end
        check("ch0_high", hi0, 2048);
        check("ch0_sync", s0, 1024);
        check("ch1_high", hi1, 1280);
        check("ch1_sync", s1, 1);
        check("ch1_sync_last", {31'd0, period_sync[1]}, 32'd1);
        check("ch2_high", hi2, 5120);
        check("ch3_high", hi3, 0);

        // Staged edits without commit: readback updates, outputs keep old duty
        wr_en = 1'b1; wr_addr = 8'd1; wr_data = 8'h04; rd_addr = 8'd1;
        cycle();
        check("rd_sw0", {24'd0, rd_data}, 32'h04);
        wr_addr = 8'd13; wr_data = 8'h00; rd_addr = 8'd13;
        cycle();
        check("rd_sw2", {24'd0, rd_data}, 32'h00);
        wr_en = 1'b0;
        hi0 = 0; hi2 = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            hi0 += int'(PWMOutputs[0]);
            hi2 += int'(PWMOutputs[2]);
        end
        check("staged_ch0_high", hi0, 4);
        check("staged_ch2_high", hi2, 10);

        // Mid-period commit: new duty only after the next period_sync[0]
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (period_sync[0]) found = 1'b1;
        end
        check("wait_sync0", {31'd0, found}, 32'd1);
        hi0 = 0; hi2 = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            hi0 += int'(PWMOutputs[0]);
            hi2 += int'(PWMOutputs[2]);
        end
        check("new_ch0_high", hi0, 4);
        check("new_ch2_high", hi2, 0);

        // Out-of-range write is ignored, then reset aborts the running period
        wr_en = 1'b1; wr_addr = 8'd24; wr_data = 8'hFF; rd_addr = 8'd24;
        cycle();
        check("rd_oob", {24'd0, rd_data}, 32'd0);
        wr_en = 1'b0; rd_addr = 8'd1;
        cycle();
        check("rd_keep", {24'd0, rd_data}, 32'h04);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("midrst_pwm", {28'd0, PWMOutputs}, 32'd0);
        check("midrst_sync", {28'd0, period_sync}, 32'd0);
        check("midrst_rd", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
